// File: rtl/nios_led3_cpu_debug_scan_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : nios_led3_cpu_debug_scan_master
// Purpose  : Host-side driver for the CPU debug slave's virtual-JTAG port,
//            operating entirely in the system clock domain. One command
//            (2-bit virtual IR plus DR_LEN-bit DR payload) is accepted at a
//            time. The block walks the virtual-JTAG states
//            UIR -> CDR -> SDR -> E1DR -> RTI, generates tck and serial tdi,
//            samples tdo into a shift register and reports the captured word.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   cmd_valid      in   command offered
//   cmd_ready      out  block idle; accept on cmd_valid & cmd_ready
//   cmd_ir         in   [1:0]        virtual IR for the command
//   cmd_dr         in   [DR_LEN-1:0] payload, shifted out LSB first
//   rsp_valid      out  one-cycle pulse, rsp_data valid
//   rsp_data       out  [DR_LEN-1:0] captured tdo bits, first at LSB
//   tck            out  generated scan clock
//   tdi            out  serial data to slave
//   tdo            in   serial data from slave
//   ir_in          out  [1:0] latched virtual IR
//   vs_uir/vs_cdr/vs_sdr/vs_e1dr  out  virtual state strobes
//   jtag_state_rti out  run-test-idle indicator
// ============================================================================
module nios_led3_cpu_debug_scan_master #(
  parameter int DR_LEN     = 38,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_ir,
  input  logic [DR_LEN-1:0] cmd_dr,
  output logic              rsp_valid,
  output logic [DR_LEN-1:0] rsp_data,
  output logic              tck,
  output logic              tdi,
  input  logic              tdo,
  output logic [1:0]        ir_in,
  output logic              vs_uir,
  output logic              vs_cdr,
  output logic              vs_sdr,
  output logic              vs_e1dr,
  output logic              jtag_state_rti
);

  // One tck period is PERIOD clk cycles: TCK_DIV low, then TCK_DIV high.
  localparam int PERIOD = 2 * TCK_DIV;
  localparam int CW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int BMAX   = (DR_LEN > RTI_CYCLES) ? DR_LEN : RTI_CYCLES;
  localparam int BW     = $clog2(BMAX + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] CNT_RISE = CW'(TCK_DIV - 1);
  localparam logic [CW-1:0] CNT_HIGH = CW'(TCK_DIV);
  localparam logic [BW-1:0] BIT_LAST_DR  = BW'(DR_LEN - 1);
  localparam logic [BW-1:0] BIT_LAST_RTI = BW'(RTI_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_E1DR = 3'd4,
    S_RTI  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;          // clk cycle within tck period
  logic [BW-1:0]     bit_cnt, bit_nxt;      // SDR bit / RTI period index
  logic [DR_LEN-1:0] sr, sr_nxt;            // shift register out/in
  logic              accept;
  logic              period_end;
  logic              in_scan_nxt;
  logic              tck_nxt;
  logic              tdi_nxt;

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_cnt;
    sr_nxt     = sr;
    accept     = 1'b0;
    period_end = (cnt == CNT_LAST);

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = S_UIR;
          bit_nxt   = '0;
          sr_nxt    = cmd_dr;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end

      default: begin
        cnt_nxt = period_end ? '0 : cnt + CW'(1);

        // tdo is captured on the edge where tck rises, mid-period.
        if (state == S_SDR && cnt == CNT_RISE) begin
          sr_nxt = {tdo, sr[DR_LEN-1:1]};
        end

        if (period_end) begin
          case (state)
            S_UIR:  state_nxt = S_CDR;
            S_CDR: begin
              state_nxt = S_SDR;
              bit_nxt   = '0;
            end
            S_SDR: begin
              if (bit_cnt == BIT_LAST_DR) begin
                state_nxt = S_E1DR;
                bit_nxt   = '0;
              end else begin
                bit_nxt = bit_cnt + BW'(1);
              end
            end
            S_E1DR: begin
              state_nxt = S_RTI;
              bit_nxt   = '0;
            end
            S_RTI: begin
              if (bit_cnt == BIT_LAST_RTI) begin
                state_nxt = S_DONE;
                bit_nxt   = '0;
              end else begin
                bit_nxt = bit_cnt + BW'(1);
              end
            end
            default: state_nxt = S_IDLE;
          endcase
        end
      end
    endcase

    in_scan_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
    tck_nxt     = in_scan_nxt && (cnt_nxt >= CNT_HIGH);

    // tdi only moves at the start of a period; sr has already been shifted
    // by the previous period's capture, so sr_nxt[0] is the next bit to send.
    tdi_nxt = tdi;
    if (state_nxt != S_SDR) begin
      tdi_nxt = 1'b0;
    end else if (cnt_nxt == '0) begin
      tdi_nxt = sr_nxt[0];
    end
  end

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bit_cnt        <= '0;
      sr             <= '0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      tck            <= 1'b0;
      tdi            <= 1'b0;
      ir_in          <= 2'b00;
      vs_uir         <= 1'b0;
      vs_cdr         <= 1'b0;
      vs_sdr         <= 1'b0;
      vs_e1dr        <= 1'b0;
      jtag_state_rti <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      bit_cnt        <= bit_nxt;
      sr             <= sr_nxt;
      cmd_ready      <= (state_nxt == S_IDLE);
      rsp_valid      <= (state_nxt == S_DONE);
      tck            <= tck_nxt;
      tdi            <= tdi_nxt;
      vs_uir         <= (state_nxt == S_UIR);
      vs_cdr         <= (state_nxt == S_CDR);
      vs_sdr         <= (state_nxt == S_SDR);
      vs_e1dr        <= (state_nxt == S_E1DR);
      jtag_state_rti <= (state_nxt == S_RTI);
      if (accept) begin
        ir_in <= cmd_ir;
      end
      // rsp_data holds between responses.
      if (state_nxt == S_DONE) begin
        rsp_data <= sr_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/nios_led3_cpu_debug_scan_master.md
# nios_led3_cpu_debug_scan_master

Host-side driver for the CPU debug slave's virtual-JTAG port, running entirely in the system clock domain. It accepts one command (2-bit IR, DR_LEN-bit DR payload) and sequences the virtual-JTAG state strobes, tck, and serial tdi that the debug slave's tck-side logic consumes. It samples tdo into a response word and reports it. Used for in-system debug bring-up and simulation, where no physical JTAG hub is present.

## Interface
Parameters:
- DR_LEN, 38, data-register length in bits (>=2)
- TCK_DIV, 2, clk cycles per tck half-period (>=1)
- RTI_CYCLES, 2, tck periods spent in run-test-idle after each scan (>=1)

Ports (one clock `clk`; reset `reset` is synchronous, active-high):
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  block idle; command accepted when cmd_valid & cmd_ready
- cmd_ir  input  2  virtual IR value for this command
- cmd_dr  input  DR_LEN  payload shifted out LSB first
- rsp_valid  output  1  one-cycle pulse, rsp_data valid
- rsp_data  output  DR_LEN  bits captured from tdo, first-captured bit at LSB
- tck  output  1  generated scan clock
- tdi  output  1  serial data to slave
- tdo  input  1  serial data from slave
- ir_in  output  2  virtual IR to slave
- vs_uir, vs_cdr, vs_sdr, vs_e1dr  output  1 each  virtual state strobes
- jtag_state_rti  output  1  run-test-idle indicator

## Operation
- States: IDLE -> UIR -> CDR -> SDR -> E1DR -> RTI -> DONE -> IDLE.
- IDLE: cmd_ready=1, all strobes 0, tck=0. On accept, latch cmd_ir into ir_in, latch cmd_dr into shift register sr, zero bit counter, go to UIR.
- Each JTAG state (UIR, CDR, one SDR bit, E1DR, one RTI period) lasts exactly one tck period: TCK_DIV cycles tck=0, then TCK_DIV cycles tck=1.
- A strobe equals 1 for the full period of its state. It and tdi change only on the clk edge that starts a period (tck falling/low phase).
- SDR: DR_LEN periods. tdi=sr[0] throughout a period. On the clk edge where tck goes 0->1, sample tdo: sr <= {tdo, sr[DR_LEN-1:1]}. After DR_LEN samples, go to E1DR.
- tdi=0 outside SDR.
- RTI: RTI_CYCLES periods with jtag_state_rti=1.
- DONE: one clk cycle. rsp_valid=1, rsp_data<=sr. rsp_data then holds until the next DONE.
- ir_in holds the latched value after the command ends, until the next accept.
- cmd_valid while busy: ignored, not queued. cmd_ir/cmd_dr are sampled only at the accept edge.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, tck=0, tdi=0, ir_in=0, all vs_* =0, jtag_state_rti=0. The block is in IDLE.
- Accept at edge T. UIR begins at T+1. Total scan = (3+DR_LEN+RTI_CYCLES)*2*TCK_DIV cycles. rsp_valid is high in cycle T+1+scan; defaults give T+173.
- cmd_ready falls the cycle after accept and returns the cycle after rsp_valid. Minimum command-to-command spacing = scan+2 cycles.
- tdo is sampled on the edge tck rises, i.e. TCK_DIV cycles after tdi is driven.
- Reset asserted in any state, including mid-SDR: the next cycle shows all reset values. The partial response is discarded and no rsp_valid is issued.
- Reset coincident with cmd_valid: the command is not accepted.

## Test plan
- Loopback (tdo=tdi), cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_A5A5 -> ir_in=01 from UIR onward. rsp_valid at accept+173. rsp_data=38'h2A_5A5A_A5A5.
- tdo tied 1, cmd_dr=0 -> rsp_data=38'h3F_FFFF_FFFF. tdi=0 in every SDR period. Exactly 38 vs_sdr tck periods, each 2 clk low + 2 clk high.
- Strobe order check, defaults -> vs_uir 4 cycles, vs_cdr 4, vs_sdr 152, vs_e1dr 4, jtag_state_rti 8. Never two strobes high together.
- Reset asserted at the 20th SDR bit -> next cycle all outputs at reset values, no rsp_valid. A fresh command afterwards completes normally with correct loopback data.
- Back-to-back: cmd_valid held high with a second command -> second accept exactly one cycle after the first rsp_valid. rsp_data updates to the second result.
- TCK_DIV=1, DR_LEN=8, RTI_CYCLES=1, loopback cmd_dr=8'h81 -> tck toggles every cycle, rsp_valid at accept+25, rsp_data=8'h81.
